process_scheduler: RTL and testbench

Round-robin process scheduler and quantum timer that sequences the program counter between user processes and the operating-system context-switch routine. It counts retired user instructions per process and preempts on quantum expiry or process end. On each switch it saves the running process's PC into an internal process table, vectors the PC to the OS entry point, and waits for the OS to finish. It then dispatches the next ready process by reloading that process's saved PC. It sits between the instruction-retire logic and the PC register.

---
 rtl/jups_sched_pkg.sv | 18 +
 rtl/rr_picker.sv | 32 +++
 rtl/process_scheduler.sv | 137 +++++++++++++
 tb/tb_process_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/jups_sched_pkg.sv
// Shared definitions for the round-robin process scheduler.
package jups_sched_pkg;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned QCNT_W          = 5;
  localparam int unsigned DEF_NUM_PROC    = 4;
  localparam int unsigned DEF_QUANTUM     = 10;
  localparam logic [31:0] DEF_SO_ENTRY_PC = 32'd17;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_SAVE     = 3'd2,
    ST_OS       = 3'd3,
    ST_DISPATCH = 3'd4
  } sched_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first ready slot at or after i_start, wrapping.
// With i_incl_start low the start slot itself is never selected.
module rr_picker
  import jups_sched_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_PROC,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_ready,
  input  logic [IW-1:0] i_start,
  input  logic          i_incl_start,
  output logic          o_found_c,
  output logic [IW-1:0] o_idx_c
);

  logic [IW-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest ready slot wins.
  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = i_start;
    w_idx     = i_start;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      w_idx = i_start + IW'(i);
      if (i_ready[w_idx] && ((i != 0) || i_incl_start)) begin
        o_found_c = 1'b1;
        o_idx_c   = w_idx;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler with per-process quantum timer and OS hand-off.
module process_scheduler
  import jups_sched_pkg::*;
#(
  parameter int unsigned NUM_PROC    = DEF_NUM_PROC,
  parameter int unsigned QUANTUM     = DEF_QUANTUM,
  parameter logic [31:0] SO_ENTRY_PC = DEF_SO_ENTRY_PC,
  parameter int unsigned IW          = $clog2(NUM_PROC)
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_instr_valid,
  input  logic            i_end_proc,
  input  logic [PC_W-1:0] i_pc_curr,
  input  logic            i_so_done,
  input  logic            i_proc_load,
  input  logic [IW-1:0]   i_proc_load_id,
  input  logic [PC_W-1:0] i_proc_load_pc,
  output logic            o_enable_so,
  output logic            o_pc_load,
  output logic [PC_W-1:0] o_pc_new,
  output logic [IW-1:0]   o_cur_proc,
  output logic            o_idle
);

  sched_state_e    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc_table [NUM_PROC];
  logic [NUM_PROC-1:0] r_ready;
  logic [QCNT_W-1:0]   r_qcount, w_qcount_nxt;
  logic [IW-1:0]       r_cur_proc, w_cur_nxt;
  logic                r_enable_so, r_pc_load, r_idle;
  logic [PC_W-1:0]     r_pc_new, w_pc_new_nxt;
  logic                w_save, w_end, w_load_ok;
  logic                w_pick_found;
  logic [IW-1:0]       w_pick_idx, w_pick_start;
  logic [PC_W-1:0]     w_pick_pc;

  // Searching from cur_proc+1 over all slots leaves cur_proc for last.
  assign w_pick_start = r_cur_proc + IW'(1);

  rr_picker #(.N(NUM_PROC), .IW(IW)) u_picker (
    .i_ready      (r_ready),
    .i_start      (w_pick_start),
    .i_incl_start (1'b1),
    .o_found_c    (w_pick_found),
    .o_idx_c      (w_pick_idx)
  );

  // The running slot cannot be re-registered while its context is live.
  assign w_load_ok = i_proc_load &&
                     !(((r_state == ST_RUN) || (r_state == ST_SAVE)) &&
                       (i_proc_load_id == r_cur_proc));

  // Forward a same-cycle registration so the dispatched PC is never stale.
  assign w_pick_pc = (w_load_ok && (i_proc_load_id == w_pick_idx)) ?
                     i_proc_load_pc : r_pc_table[w_pick_idx];

  // Next-state, quantum counter and next registered outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_qcount_nxt = r_qcount;
    w_cur_nxt    = r_cur_proc;
    w_save       = 1'b0;
    w_end        = 1'b0;
    w_pc_new_nxt = r_pc_new;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) w_state_nxt = ST_DISPATCH;
      end
      ST_RUN: begin
        if (i_end_proc) begin
          w_end        = 1'b1;
          w_save       = 1'b1;
          w_qcount_nxt = '0;
          w_state_nxt  = ST_SAVE;
        end else if (i_instr_valid) begin
          if (r_qcount == QCNT_W'(QUANTUM - 1)) begin
            w_save       = 1'b1;
            w_qcount_nxt = '0;
            w_state_nxt  = ST_SAVE;
          end else begin
            w_qcount_nxt = r_qcount + QCNT_W'(1);
          end
        end
      end
      ST_SAVE: w_state_nxt = ST_OS;
      ST_OS: begin
        if (i_so_done) w_state_nxt = w_pick_found ? ST_DISPATCH : ST_IDLE;
      end
      ST_DISPATCH: w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_DISPATCH) begin
      w_cur_nxt    = w_pick_idx;
      w_qcount_nxt = '0;
      w_pc_new_nxt = w_pick_pc;
    end else if (w_state_nxt == ST_SAVE) begin
      w_pc_new_nxt = SO_ENTRY_PC;
    end
  end

  // State, process table and registered outputs.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= '0;
      r_qcount    <= '0;
      r_cur_proc  <= IW'(NUM_PROC - 1);
      r_enable_so <= 1'b1;
      r_idle      <= 1'b1;
      r_pc_load   <= 1'b0;
      r_pc_new    <= SO_ENTRY_PC;
      for (int i = 0; i < int'(NUM_PROC); i++) r_pc_table[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_qcount    <= w_qcount_nxt;
      r_cur_proc  <= w_cur_nxt;
      r_pc_new    <= w_pc_new_nxt;
      r_pc_load   <= (w_state_nxt == ST_SAVE) || (w_state_nxt == ST_DISPATCH);
      r_enable_so <= !((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DISPATCH));
      r_idle      <= (w_state_nxt == ST_IDLE);
      if (w_load_ok) begin
        r_ready[i_proc_load_id]    <= 1'b1;
        r_pc_table[i_proc_load_id] <= i_proc_load_pc;
      end
      if (w_save) r_pc_table[r_cur_proc] <= i_pc_curr;
      if (w_end)  r_ready[r_cur_proc] <= 1'b0;
    end
  end

  assign o_enable_so = r_enable_so;
  assign o_pc_load   = r_pc_load;
  assign o_pc_new    = r_pc_new;
  assign o_cur_proc  = r_cur_proc;
  assign o_idle      = r_idle;

endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench for process_scheduler: every pc_load pulse is matched against a queued expectation.
module tb_process_scheduler;

  typedef struct packed {
    logic [31:0] pc;
    logic        en;
    logic [1:0]  cur;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, end_proc, so_done, proc_load;
  logic [31:0] pc_curr, proc_load_pc;
  logic [1:0]  proc_load_id;
  logic        enable_so, pc_load, idle;
  logic [31:0] pc_new;
  logic [1:0]  cur_proc;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  process_scheduler dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_instr_valid  (instr_valid),
    .i_end_proc     (end_proc),
    .i_pc_curr      (pc_curr),
    .i_so_done      (so_done),
    .i_proc_load    (proc_load),
    .i_proc_load_id (proc_load_id),
    .i_proc_load_pc (proc_load_pc),
    .o_enable_so    (enable_so),
    .o_pc_load      (pc_load),
    .o_pc_new       (pc_new),
    .o_cur_proc     (cur_proc),
    .o_idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each pc_load pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && pc_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pc_load", pc_new, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc_new", pc_new, e.pc);
        chk("sb_enable_so", 32'(enable_so), 32'(e.en));
        chk("sb_cur_proc", 32'(cur_proc), 32'(e.cur));
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic en, input logic [1:0] cur);
    exp_t e;
    e.pc = pc; e.en = en; e.cur = cur;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [1:0] id, input logic [31:0] pc);
    proc_load = 1'b1; proc_load_id = id; proc_load_pc = pc;
    tick();
    proc_load = 1'b0;
  endtask

  task automatic run_slice(input int n, input logic [31:0] last_pc,
                           input logic end_last, input logic exp_switch);
    for (int k = 0; k < n; k++) begin
      instr_valid = 1'b1;
      end_proc    = (k == n - 1) && end_last;
      pc_curr     = (k == n - 1) ? last_pc : 32'h1000 + 32'(k);
      tick();
      if (k < n - 1) chk("slice_no_early_load", 32'(pc_load), 32'd0);
      else begin
        chk("slice_switch_load", 32'(pc_load), 32'(exp_switch));
        chk("slice_enable_so", 32'(enable_so), 32'(exp_switch));
      end
    end
    instr_valid = 1'b0;
    end_proc    = 1'b0;
  endtask

  // From SAVE: reach OS, pulse so_done, check dispatch or return to idle.
  task automatic os_return(input logic exp_dispatch);
    tick();
    chk("os_enable_so", 32'(enable_so), 32'd1);
    so_done = 1'b1;
    tick();
    so_done = 1'b0;
    chk("os_ret_pc_load", 32'(pc_load), 32'(exp_dispatch));
    chk("os_ret_idle", 32'(idle), 32'(!exp_dispatch));
    tick();
  endtask

  task automatic chk_reset_outs();
    chk("rst_enable_so", 32'(enable_so), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_pc_new", pc_new, 32'd17);
    chk("rst_cur_proc", 32'(cur_proc), 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; end_proc = 1'b0; so_done = 1'b0;
    proc_load = 1'b0; proc_load_id = '0; proc_load_pc = '0; pc_curr = '0;
    tick(); tick();
    chk_reset_outs();
    rst_n = 1'b1;

    // First registration dispatches slot 0 two cycles later.
    push(32'h40, 1'b0, 2'd0);
    load(2'd0, 32'h40);
    chk("load_not_yet", 32'(pc_load), 32'd0);
    tick();
    chk("first_dispatch_load", 32'(pc_load), 32'd1);
    chk("first_dispatch_pc", pc_new, 32'h40);
    tick();
    chk("run_pc_load_low", 32'(pc_load), 32'd0);
    chk("pc_new_holds", pc_new, 32'h40);

    // Quantum expiry of proc 0, then proc 1 dispatched.
    push(32'd17, 1'b1, 2'd0);
    run_slice(10, 32'h68, 1'b0, 1'b1);
    load(2'd1, 32'h80);
    push(32'h80, 1'b0, 2'd1);
    os_return(1'b1);

    // Proc 1 expires, proc 0 resumes at its saved PC.
    push(32'd17, 1'b1, 2'd1);
    run_slice(10, 32'h90, 1'b0, 1'b1);
    push(32'h68, 1'b0, 2'd0);
    os_return(1'b1);
    chk("resume_cur_proc", 32'(cur_proc), 32'd0);

    // End coinciding with expiry retires proc 0; proc 1 dispatched.
    push(32'd17, 1'b1, 2'd0);
    run_slice(10, 32'hA0, 1'b1, 1'b1);
    push(32'h90, 1'b0, 2'd1);
    os_return(1'b1);

    // Re-registering the running slot is ignored; its end leaves nothing ready.
    load(2'd1, 32'hEE);
    push(32'd17, 1'b1, 2'd1);
    run_slice(1, 32'hB0, 1'b1, 1'b1);
    os_return(1'b0);
    tick(); tick(); tick();
    chk("idle_stays", 32'(idle), 32'd1);
    chk("idle_enable_so", 32'(enable_so), 32'd1);
    chk("idle_cur_proc", 32'(cur_proc), 32'd1);

    // Dispatch from IDLE searches from cur_proc+1; then reset mid-slice.
    push(32'h200, 1'b0, 2'd2);
    load(2'd2, 32'h200);
    tick(); tick();
    run_slice(6, 32'h208, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_reset_outs();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_idle", 32'(idle), 32'd1);
    chk("post_rst_no_load", 32'(pc_load), 32'd0);

    // Quantum counter restarts from zero after reset.
    push(32'h300, 1'b0, 2'd0);
    load(2'd0, 32'h300);
    tick(); tick();
    push(32'd17, 1'b1, 2'd0);
    run_slice(10, 32'h310, 1'b0, 1'b1);
    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
